rgb_to_hsv: RTL and testbench
=============================

Name: rgb_to_hsv

Overview:
- Converts a 24-bit RGB pixel {R[23:16], G[15:8], B[7:0]} into hue (0..359), saturation (0..255) and value (0..255).
- Inverse of the LED colour path's HSV-to-RGB stage. Used by the audio-reactive and colour-picker logic to map incoming RGB colours back into the hue/val domain the LED driver consumes.
- Iterative and multi-cycle, using a valid/ready input handshake and a fixed latency.

Parameters:
- DIV_W, 16, width of the dividend and iteration count of each restoring divider. Must be ≥16; 255*255 = 65025 must fit.
- LATENCY, DIV_W+2, derived constant. Clock edges from the accepting edge to the edge that raises valid_out. Not to be overridden.

Ports:
- clk_100mhz  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rgb  in  24  input pixel, {R,G,B}
- valid_in  in  1  input pixel valid
- ready_in  out  1  block can accept a pixel this cycle
- hue  out  9  hue in degrees, 0..359
- sat  out  8  saturation, 0..255
- val  out  8  value (max channel)
- valid_out  out  1  one-cycle pulse; hue/sat/val valid

Behaviour:
- Reset, asynchronous, active low:
  - state=IDLE, ready_in=1, valid_out=0, hue=0, sat=0, val=0, all divider state cleared.
  - Reset mid-operation abandons the pixel; no valid_out is produced for it.
- Handshake:
  - A pixel is accepted on an edge where valid_in && ready_in; rgb is registered on that edge (E0).
  - ready_in = (state==IDLE).
  - valid_in while ready_in=0 is ignored. The producer must hold the pixel until accepted.
- FSM IDLE -> PREP -> DIV -> DONE -> IDLE:
  - PREP (edge E1):
    - mx = max(R,G,B), mn = min, d = mx-mn.
    - Sector priority on ties: R, then G, then B.
    - Hue numerator: nh = 60*|diff|, with diff = G-B (max R), B-R (max G), R-G (max B); record sign neg = diff<0.
    - Saturation numerator: ns = 255*d.
    - Load both dividers: nh/d and ns/mx.
  - DIV (edges E2..E17): DIV_W iterations of two parallel restoring dividers, producing quotients qh and qs. Quotients truncate (floor), no rounding.
  - DONE (edge E18 = E0+LATENCY):
    - Register outputs, valid_out=1 for exactly one cycle, state returns to IDLE.
    - ready_in=1 in the same cycle valid_out=1.
    - Maximum throughput is one pixel per LATENCY+1 = 19 cycles.
- Hue assembly:
  - base = 0 / 120 / 240 for max R / G / B.
  - hue = neg ? base - qh : base + qh.
  - If the result is negative (max R only), add 360.
  - If the result equals 360, output 0. hue is always in 0..359.
- Saturation: sat = qs[7:0]. qs ≤ 255 is guaranteed.
- Value: val = mx.
- Degenerate cases:
  - d==0: hue=0 and sat=0.
  - mx==0: sat=0.
  - Divide-by-zero results are overridden in DONE. Latency is unchanged (dividers still run).
- Outputs hold their last values between valid_out pulses.
- Arithmetic: all internal intermediates are unsigned and sized so nothing truncates. Signed handling happens only in hue assembly, with 10-bit signed width.

Decomposition:
- Package colour_pkg:
  - HUE_W=9, CH_W=8, HUE_MAX=360, SECTOR_DEG=60.
  - Enum state_t {IDLE, PREP, DIV, DONE}.
  - Enum sector_t {SEC_R, SEC_G, SEC_B}.
  - The HSV-to-RGB block shares HUE_W/CH_W.
- Sub-module seq_divider (parameter W):
  - Ports: start, dividend[W-1:0], divisor[7:0], quotient[W-1:0], done.
  - Restoring, one bit per cycle, same clock and reset.
  - Instantiated twice (hue, saturation).

Test Plan:
- rgb=24'hFF0000 -> after exactly 18 edges: hue=0, sat=255, val=255, valid_out high for 1 cycle. ready_in low for those cycles.
- rgb=24'h00FF00 -> hue=120, sat=255, val=255.
- rgb=24'h0000FF -> hue=240, sat=255, val=255.
- rgb=24'hFFFF00 (R/G tie, R wins) -> hue=60, sat=255, val=255.
- rgb=24'hFF0080 -> hue=330, sat=255, val=255.
- rgb=24'h808080 -> hue=0, sat=0, val=128.
- rgb=24'h000000 -> hue=0, sat=0, val=0.
- valid_in held high with a new pixel each accept -> accepts spaced 19 cycles apart. Pixels offered while ready_in=0 are never output.
- Assert rst_n=0 at cycle 8 of a conversion -> no valid_out. Outputs read 0 immediately (asynchronously). ready_in=1 after rst_n rises; the next pixel converts correctly.

Source files
------------

// File: rtl/colour_pkg.sv
// Shared colour-space definitions for the RGB<->HSV datapaths.
// Contents:
//   HUE_W / CH_W   - hue and channel widths, also used by the HSV-to-RGB block
//   HUE_MAX        - degrees in a full hue circle
//   SECTOR_DEG     - degrees spanned by one 60-degree hue sector
//   state_t        - converter FSM states
//   sector_t       - which channel holds the maximum
package colour_pkg;

    localparam int HUE_W      = 9;
    localparam int CH_W       = 8;
    localparam int HUE_MAX    = 360;
    localparam int SECTOR_DEG = 60;

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        DIV,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        SEC_R,
        SEC_G,
        SEC_B
    } sector_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring divider producing one quotient bit per clock.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   start      - load dividend/divisor and begin W iterations
//   dividend   - W-bit unsigned numerator
//   divisor    - 8-bit unsigned denominator (zero yields a meaningless quotient)
//   quotient   - W-bit floor(dividend / divisor), valid after the final iteration
//   done       - high during the final iteration; quotient is complete after that edge
module seq_divider #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [7:0]   divisor,
    output logic [W-1:0] quotient,
    output logic         done
);

    localparam int CNT_W = $clog2(W + 1);

    logic [CNT_W-1:0] count;
    logic [8:0]       rem;
    logic [7:0]       dsr;
    logic [9:0]       shifted;
    logic             ge;

    // The quotient register doubles as the dividend shift register: its MSB
    // feeds the partial remainder while quotient bits enter at the LSB.
    assign shifted = {rem, quotient[W-1]};
    assign ge      = shifted >= {2'b00, dsr};
    assign done    = (count == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            rem      <= '0;
            dsr      <= '0;
            quotient <= '0;
        end else if (start) begin
            count    <= CNT_W'(W);
            rem      <= '0;
            dsr      <= divisor;
            quotient <= dividend;
        end else if (count != '0) begin
            rem      <= ge ? 9'(shifted - {2'b00, dsr}) : shifted[8:0];
            quotient <= {quotient[W-2:0], ge};
            count    <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/rgb_to_hsv.sv
// Multi-cycle RGB to HSV converter.
// Ports:
//   clk_100mhz - system clock
//   rst_n      - asynchronous active-low reset
//   rgb        - input pixel {R[23:16], G[15:8], B[7:0]}
//   valid_in   - input pixel valid
//   ready_in   - high while idle; a pixel is taken on valid_in && ready_in
//   hue        - hue in degrees, 0..359
//   sat        - saturation, 0..255
//   val        - value (largest channel)
//   valid_out  - one-cycle pulse LATENCY edges after the accepting edge
module rgb_to_hsv
    import colour_pkg::*;
#(
    parameter  int DIV_W   = 16,
    localparam int LATENCY = DIV_W + 2
) (
    input  logic             clk_100mhz,
    input  logic             rst_n,
    input  logic [23:0]      rgb,
    input  logic             valid_in,
    output logic             ready_in,
    output logic [HUE_W-1:0] hue,
    output logic [CH_W-1:0]  sat,
    output logic [CH_W-1:0]  val,
    output logic             valid_out
);

    state_t            state;
    logic [23:0]       pix;
    logic [CH_W-1:0]   r, g, b;
    logic [CH_W-1:0]   mx, mn, d, adiff;
    logic              neg;
    sector_t           sec;
    logic [DIV_W-1:0]  nh, ns, qh, qs;
    logic              done_h, done_s;
    logic              div_start;
    logic signed [9:0] base, frac, hue_raw;

    // Hue quotient is bounded by one sector; clamping keeps the 10-bit
    // signed assembly exact without silently dropping high quotient bits.
    function automatic logic [6:0] sector_frac(input logic [DIV_W-1:0] q);
        return (q > DIV_W'(SECTOR_DEG)) ? 7'(SECTOR_DEG) : q[6:0];
    endfunction

    function automatic logic [CH_W-1:0] sat_clip(input logic [DIV_W-1:0] q);
        return (q > DIV_W'(255)) ? 8'hFF : q[7:0];
    endfunction

    // Fold the signed sector result back onto 0..359.
    function automatic logic [HUE_W-1:0] wrap_hue(input logic signed [9:0] h);
        logic signed [9:0] t;
        t = h;
        if (t < 10'sd0) t = t + 10'(HUE_MAX);
        if (t == 10'(HUE_MAX)) t = 10'sd0;
        return HUE_W'(t);
    endfunction

    assign ready_in  = (state == IDLE);
    assign div_start = (state == PREP);

    assign r = pix[23:16];
    assign g = pix[15:8];
    assign b = pix[7:0];

    // Max/min and sector selection; ties resolve R, then G, then B.
    always_comb begin
        sec   = SEC_B;
        mx    = b;
        adiff = (r >= g) ? r - g : g - r;
        neg   = (r < g);
        if (r >= g && r >= b) begin
            sec   = SEC_R;
            mx    = r;
            adiff = (g >= b) ? g - b : b - g;
            neg   = (g < b);
        end else if (g >= b) begin
            sec   = SEC_G;
            mx    = g;
            adiff = (b >= r) ? b - r : r - b;
            neg   = (b < r);
        end
        mn = r;
        if (g < mn) mn = g;
        if (b < mn) mn = b;
        d = mx - mn;
    end

    assign nh = DIV_W'(adiff) * DIV_W'(SECTOR_DEG);
    assign ns = DIV_W'(d) * DIV_W'(255);

    always_comb begin
        case (sec)
            SEC_R:   base = 10'sd0;
            SEC_G:   base = 10'sd120;
            default: base = 10'sd240;
        endcase
        frac    = $signed({3'b000, sector_frac(qh)});
        hue_raw = neg ? base - frac : base + frac;
    end

    // Iteration count equals the DIV phase: LATENCY minus the PREP and DONE edges.
    seq_divider #(.W(LATENCY - 2)) u_div_hue (
        .clk      (clk_100mhz),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (nh),
        .divisor  (d),
        .quotient (qh),
        .done     (done_h)
    );

    seq_divider #(.W(LATENCY - 2)) u_div_sat (
        .clk      (clk_100mhz),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (ns),
        .divisor  (mx),
        .quotient (qs),
        .done     (done_s)
    );

    // Pixel is held for the whole conversion; only the accepting edge loads it.
    always_ff @(posedge clk_100mhz) begin
        if (valid_in && ready_in) pix <= rgb;
    end

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            valid_out <= 1'b0;
            hue       <= '0;
            sat       <= '0;
            val       <= '0;
        end else begin
            valid_out <= 1'b0;
            case (state)
                IDLE: if (valid_in) state <= PREP;
                PREP: state <= DIV;
                DIV:  if (done_h && done_s) state <= DONE;
                DONE: begin
                    valid_out <= 1'b1;
                    val       <= mx;
                    // A grey pixel (d==0, including black) has no defined hue
                    // and the divider results are meaningless; force zero.
                    if (d == '0) begin
                        hue <= '0;
                        sat <= '0;
                    end else begin
                        hue <= wrap_hue(hue_raw);
                        sat <= sat_clip(qs);
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rgb_to_hsv.sv
module tb_rgb_to_hsv;

    logic        clk_100mhz = 1'b0;
    logic        rst_n      = 1'b0;
    logic [23:0] rgb        = '0;
    logic        valid_in   = 1'b0;
    logic        ready_in;
    logic [8:0]  hue;
    logic [7:0]  sat;
    logic [7:0]  val;
    logic        valid_out;

    int n_cmp = 0;
    int n_bad = 0;

    rgb_to_hsv dut (
        .clk_100mhz (clk_100mhz),
        .rst_n      (rst_n),
        .rgb        (rgb),
        .valid_in   (valid_in),
        .ready_in   (ready_in),
        .hue        (hue),
        .sat        (sat),
        .val        (val),
        .valid_out  (valid_out)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    // Textbook HSV with integer arithmetic: hue sector formula with truncating
    // division, saturation = 255*(max-min)/max, value = max.
    function automatic void ref_hsv(input logic [23:0] p, output logic [8:0] h,
                                    output logic [7:0] s, output logic [7:0] v);
        int r, g, b, mx, mn, d, hh;
        r = int'(p[23:16]);
        g = int'(p[15:8]);
        b = int'(p[7:0]);
        mx = r; if (g > mx) mx = g; if (b > mx) mx = b;
        mn = r; if (g < mn) mn = g; if (b < mn) mn = b;
        d  = mx - mn;
        v  = 8'(mx);
        if (d == 0) begin
            h = 9'd0;
            s = 8'd0;
        end else begin
            s = 8'((255 * d) / mx);
            if (r == mx)      hh = (60 * (g - b)) / d;
            else if (g == mx) hh = 120 + (60 * (b - r)) / d;
            else              hh = 240 + (60 * (r - g)) / d;
            if (hh < 0)    hh = hh + 360;
            if (hh >= 360) hh = hh - 360;
            h = 9'(hh);
        end
    endfunction

    function automatic logic [7:0] pick_ch();
        case ($urandom_range(0, 3))
            0:       return 8'h00;
            1:       return 8'hFF;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    // Drives one pixel (entered #1 after a rising edge) and reports what came
    // back plus handshake observations. lat==0 means no valid_out in budget.
    task automatic convert(input logic [23:0] p, output logic [8:0] h, output logic [7:0] s,
                           output logic [7:0] v, output int lat, output bit busy_ok,
                           output bit rdy_done, output bit after_ok);
        for (int w = 0; w < 40 && !ready_in; w++) begin
            @(posedge clk_100mhz); #1;
        end
        rgb = p;
        valid_in = 1'b1;
        @(posedge clk_100mhz); #1;
        valid_in = 1'b0;
        rgb = 24'($urandom);
        busy_ok = !ready_in;
        lat = 0; rdy_done = 1'b0; after_ok = 1'b0;
        h = '0; s = '0; v = '0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk_100mhz); #1;
            if (valid_out) begin
                lat = k;
                h = hue; s = sat; v = val;
                rdy_done = ready_in;
                break;
            end
            if (ready_in) busy_ok = 1'b0;
        end
        if (lat != 0) begin
            @(posedge clk_100mhz); #1;
            after_ok = !valid_out && hue === h && sat === s && val === v;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        valid_in = 1'b0;
        repeat (3) @(posedge clk_100mhz);
        #1;
        n_cmp++;
        if ({ready_in, valid_out, hue, sat, val} !== {1'b1, 1'b0, 9'd0, 8'd0, 8'd0}) begin
            n_bad++;
            $display("FAIL reset_state: got rdy=%0b vo=%0b h=%0d s=%0d v=%0d, want rdy=1 vo=0 h=0 s=0 v=0",
                     ready_in, valid_out, hue, sat, val);
        end
        @(negedge clk_100mhz);
        rst_n = 1'b1;
        @(posedge clk_100mhz); #1;
    endtask

    task automatic test_directed();
        logic [23:0] pv [7] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00,
                                24'hFF0080, 24'h808080, 24'h000000};
        logic [8:0]  eh [7] = '{9'd0, 9'd120, 9'd240, 9'd60, 9'd330, 9'd0, 9'd0};
        logic [7:0]  es [7] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd0, 8'd0};
        logic [7:0]  ev [7] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd128, 8'd0};
        logic [8:0] h; logic [7:0] s, v; int lat; bit bo, rd, ao;
        for (int i = 0; i < 7; i++) begin
            convert(pv[i], h, s, v, lat, bo, rd, ao);
            n_cmp++;
            if ({h, s, v} !== {eh[i], es[i], ev[i]}) begin
                n_bad++;
                $display("FAIL directed_%06h: got h=%0d s=%0d v=%0d, want h=%0d s=%0d v=%0d",
                         pv[i], h, s, v, eh[i], es[i], ev[i]);
            end
            n_cmp++;
            if (lat !== 18 || !bo || !rd || !ao) begin
                n_bad++;
                $display("FAIL timing_%06h: got lat=%0d busy_low=%0b rdy_at_done=%0b pulse_hold=%0b, want 18/1/1/1",
                         pv[i], lat, bo, rd, ao);
            end
        end
    endtask

    task automatic test_random();
        logic [23:0] p; logic [8:0] h, eh; logic [7:0] s, v, es, ev;
        int lat; bit bo, rd, ao;
        for (int i = 0; i < 30; i++) begin
            p = {pick_ch(), pick_ch(), pick_ch()};
            if ($urandom_range(0, 4) == 0) p[15:8] = p[23:16];
            if ($urandom_range(0, 4) == 0) p[7:0]  = p[15:8];
            ref_hsv(p, eh, es, ev);
            convert(p, h, s, v, lat, bo, rd, ao);
            n_cmp++;
            if ({h, s, v} !== {eh, es, ev} || lat !== 18) begin
                n_bad++;
                $display("FAIL random_%06h: got h=%0d s=%0d v=%0d lat=%0d, want h=%0d s=%0d v=%0d lat=18",
                         p, h, s, v, lat, eh, es, ev);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] pq [4];
        int acc [4];
        int sent = 0, got = 0, cyc = 0;
        logic [8:0] eh; logic [7:0] es, ev;
        for (int i = 0; i < 4; i++) pq[i] = 24'($urandom);
        rgb = pq[0];
        valid_in = 1'b1;
        acc[0] = 1;
        sent = 1;
        while (got < 4 && cyc < 200) begin
            @(posedge clk_100mhz); #1;
            cyc++;
            if (valid_out) begin
                ref_hsv(pq[got], eh, es, ev);
                n_cmp++;
                if ({hue, sat, val} !== {eh, es, ev}) begin
                    n_bad++;
                    $display("FAIL b2b_out%0d: got h=%0d s=%0d v=%0d, want h=%0d s=%0d v=%0d",
                             got, hue, sat, val, eh, es, ev);
                end
                got++;
            end
            if (ready_in && sent < 4) begin
                rgb = pq[sent];
                acc[sent] = cyc + 1;
                sent++;
            end else if (ready_in) begin
                valid_in = 1'b0;
            end else begin
                rgb = 24'($urandom);
            end
        end
        valid_in = 1'b0;
        n_cmp++;
        if (got !== 4) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d outputs, want 4", got);
        end
        for (int i = 1; i < sent; i++) begin
            n_cmp++;
            if (acc[i] - acc[i-1] !== 19) begin
                n_bad++;
                $display("FAIL b2b_spacing%0d: got %0d cycles, want 19", i, acc[i] - acc[i-1]);
            end
        end
        repeat (2) @(posedge clk_100mhz);
        #1;
    endtask

    task automatic test_reset_mid();
        logic [8:0] h, eh; logic [7:0] s, v, es, ev; int lat; bit bo, rd, ao;
        bit seen = 1'b0;
        convert(24'h12ABCD, h, s, v, lat, bo, rd, ao);
        ref_hsv(24'h12ABCD, eh, es, ev);
        n_cmp++;
        if ({h, s, v} !== {eh, es, ev}) begin
            n_bad++;
            $display("FAIL pre_reset_pixel: got h=%0d s=%0d v=%0d, want h=%0d s=%0d v=%0d",
                     h, s, v, eh, es, ev);
        end
        rgb = 24'hFF0000;
        valid_in = 1'b1;
        @(posedge clk_100mhz); #1;
        valid_in = 1'b0;
        repeat (7) @(posedge clk_100mhz);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ready_in, valid_out, hue, sat, val} !== {1'b1, 1'b0, 9'd0, 8'd0, 8'd0}) begin
            n_bad++;
            $display("FAIL async_reset: got rdy=%0b vo=%0b h=%0d s=%0d v=%0d, want rdy=1 vo=0 h=0 s=0 v=0",
                     ready_in, valid_out, hue, sat, val);
        end
        repeat (2) @(posedge clk_100mhz);
        @(negedge clk_100mhz);
        rst_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk_100mhz); #1;
            if (valid_out) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0 || ready_in !== 1'b1) begin
            n_bad++;
            $display("FAIL abandoned_pixel: got valid_out_seen=%0b ready=%0b, want 0 and 1", seen, ready_in);
        end
        convert(24'h3366CC, h, s, v, lat, bo, rd, ao);
        ref_hsv(24'h3366CC, eh, es, ev);
        n_cmp++;
        if ({h, s, v} !== {eh, es, ev} || lat !== 18) begin
            n_bad++;
            $display("FAIL post_reset_pixel: got h=%0d s=%0d v=%0d lat=%0d, want h=%0d s=%0d v=%0d lat=18",
                     h, s, v, lat, eh, es, ev);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
